multi_key_debouncer: RTL and testbench
======================================

MULTI_KEY_DEBOUNCER -- requirements
Module: multi_key_debouncer

Interface
REQ-001 Parameter pChannels, default 8: number of independent key channels, range 1..32.
REQ-002 Parameter pSampleTime, default 15: consecutive ticks a new level must persist to be accepted, range 1..2^16-1.
REQ-003 Parameter pClockDividerFactor, default 1000000: clocks per sample tick, range 1..2^32-1; a value of 1 means a tick every clock.
REQ-004 Parameter pRepeatDelay, default 0: ticks from accepted press to first repeat pulse; 0 disables auto-repeat.
REQ-005 Parameter pRepeatPeriod, default 0: ticks between subsequent repeat pulses, range 1..2^16-1 when pRepeatDelay > 0.
REQ-006 iwClk  input  1  sole clock; all state updates on its rising edge.
REQ-007 iwRst  input  1  reset, synchronous and active-high.
REQ-008 iwKeyIn  input  pChannels  raw asynchronous key levels, 1 = pressed.
REQ-009 orKeyOut  output  pChannels  debounced level per channel.
REQ-010 orPress  output  pChannels  one-clock pulse when the channel's orKeyOut rises.
REQ-011 orRelease  output  pChannels  one-clock pulse when the channel's orKeyOut falls.
REQ-012 orRepeat  output  pChannels  one-clock auto-repeat pulse while the channel is held.

Function
REQ-013 Each iwKeyIn bit SHALL pass through a 2-flop synchronizer; only the second-stage value (sync) feeds the remaining logic.
REQ-014 A shared 32-bit prescaler SHALL count 0..pClockDividerFactor-1, wrapping to 0; tick is high for the single clock in which the count equals pClockDividerFactor-1.
REQ-015 On each tick, per channel: if sync equals orKeyOut, the channel counter SHALL clear to 0; otherwise it SHALL increment.
REQ-016 When the counter would reach pSampleTime, orKeyOut SHALL take sync on that same edge and the counter SHALL clear; counters never exceed pSampleTime-1.
REQ-017 Counters and orKeyOut SHALL hold between ticks; a level differing for fewer than pSampleTime consecutive ticks SHALL never change orKeyOut.
REQ-018 With pClockDividerFactor=1, a clean step on iwKeyIn SHALL appear on orKeyOut exactly pSampleTime+2 edges after the first edge that samples it.
REQ-019 orPress/orRelease SHALL be registered and asserted for exactly the one clock following the edge at which orKeyOut changes (concurrent with the new orKeyOut value).
REQ-020 Per-channel hold counter (16 bit): cleared on accepted press; increments on each tick while orKeyOut=1; cleared when orKeyOut=0.
REQ-021 When pRepeatDelay>0, orRepeat SHALL pulse one clock on the tick where hold count reaches pRepeatDelay, then every pRepeatPeriod ticks after that while held; the hold counter reloads accordingly and never wraps.
REQ-022 orRepeat SHALL never assert in the same clock as orPress or orRelease of the same channel, nor while orKeyOut=0.
REQ-023 Channels SHALL be fully independent; simultaneous events on any subset of channels SHALL each produce their own pulses in the same clock.
REQ-024 pRepeatDelay=0 SHALL hold orRepeat at 0 permanently.

Reset
REQ-025 While iwRst=1 at a rising edge: synchronizer flops, prescaler, all counters, orKeyOut, orPress, orRelease, orRepeat SHALL become 0.
REQ-026 Reset asserted mid-count or mid-hold SHALL discard all progress; no pulse SHALL be emitted in the clock following a reset edge.
REQ-027 After reset release, a key held at 1 SHALL be accepted as a fresh press (orPress pulse) after the REQ-018 latency.

Verification (pChannels=4, pSampleTime=3, pClockDividerFactor=1, pRepeatDelay=10, pRepeatPeriod=4 unless stated)
REQ-028 Clean step iwKeyIn[0] 0->1 held -> orKeyOut[0]=1 and orPress[0]=1 for one clock, 5 edges after first sampling edge; other channels stay 0.
REQ-029 Bounce: iwKeyIn[1] high 2 clocks, low 1, high 2, then low -> orKeyOut[1] stays 0, no orPress[1].
REQ-030 Hold iwKeyIn[2] for 40 clocks -> orPress at t, orRepeat at t+10, t+14, t+18, ...; release -> orRelease 5 edges later, no further orRepeat.
REQ-031 All 4 channels stepped in the same clock -> orPress=4'b1111 in one clock; release likewise gives orRelease=4'b1111.
REQ-032 pClockDividerFactor=4: step held -> orKeyOut changes only on tick edges, after 3 ticks; a 10-clock glitch (2 ticks) is rejected.
REQ-033 Assert iwRst for 1 clock with counter at 2 and key held high -> all outputs 0 next clock, then a fresh orPress 5 edges after release.

Source files
------------

// File: rtl/multi_key_debouncer.sv
// Per-channel key debouncer with a shared sample-tick prescaler, press/release
// edge pulses and optional auto-repeat while a key stays held.
module multi_key_debouncer #(
  parameter int unsigned pChannels           = 8,
  parameter int unsigned pSampleTime         = 15,
  parameter int unsigned pClockDividerFactor = 1000000,
  parameter int unsigned pRepeatDelay        = 0,
  parameter int unsigned pRepeatPeriod       = 0
) (
  input  logic                 iwClk,
  input  logic                 iwRst,
  input  logic [pChannels-1:0] iwKeyIn,
  output logic [pChannels-1:0] orKeyOut,
  output logic [pChannels-1:0] orPress,
  output logic [pChannels-1:0] orRelease,
  output logic [pChannels-1:0] orRepeat
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIV_W = 32;

  localparam logic [DIV_W-1:0] LP_DIV_LAST    = DIV_W'(pClockDividerFactor - 1);
  localparam logic [CNT_W-1:0] LP_SAMPLE_LAST = CNT_W'(pSampleTime - 1);
  localparam logic [CNT_W-1:0] LP_DELAY_LAST  = CNT_W'(pRepeatDelay - 1);
  localparam logic [CNT_W-1:0] LP_PERIOD_LAST = CNT_W'(pRepeatPeriod - 1);
  localparam bit               LP_REPEAT_EN   = (pRepeatDelay != 0);

  logic [pChannels-1:0] r_meta;
  logic [pChannels-1:0] r_sync;
  logic [DIV_W-1:0]     r_div;
  logic [CNT_W-1:0]     r_cnt   [pChannels];
  logic [CNT_W-1:0]     r_hold  [pChannels];
  logic [pChannels-1:0] r_phase;

  logic                 w_tick;
  logic [CNT_W-1:0]     w_cnt_nxt  [pChannels];
  logic [CNT_W-1:0]     w_hold_nxt [pChannels];
  logic [pChannels-1:0] w_phase_nxt;
  logic [pChannels-1:0] w_key_nxt;
  logic [pChannels-1:0] w_press_nxt;
  logic [pChannels-1:0] w_rel_nxt;
  logic [pChannels-1:0] w_rep_nxt;

  assign w_tick = (r_div == LP_DIV_LAST);

  // Per-channel stability counting, edge detection and repeat scheduling; only
  // tick clocks can change state, pulses default low on every other clock.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    w_phase_nxt = r_phase;
    w_key_nxt   = orKeyOut;
    w_press_nxt = '0;
    w_rel_nxt   = '0;
    w_rep_nxt   = '0;
    if (w_tick) begin
      for (int i = 0; i < int'(pChannels); i++) begin
        if (r_sync[i] == orKeyOut[i]) begin
          w_cnt_nxt[i] = '0;
        end else if (r_cnt[i] == LP_SAMPLE_LAST) begin
          w_cnt_nxt[i]   = '0;
          w_key_nxt[i]   = r_sync[i];
          w_press_nxt[i] = r_sync[i];
          w_rel_nxt[i]   = ~r_sync[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
        end

        // Hold timing only runs across ticks where the key stays accepted-high.
        if (orKeyOut[i] && w_key_nxt[i]) begin
          if (LP_REPEAT_EN) begin
            if (r_hold[i] == (r_phase[i] ? LP_PERIOD_LAST : LP_DELAY_LAST)) begin
              w_rep_nxt[i]   = 1'b1;
              w_hold_nxt[i]  = '0;
              w_phase_nxt[i] = 1'b1;
            end else begin
              w_hold_nxt[i] = r_hold[i] + CNT_W'(1);
            end
          end
        end else begin
          w_hold_nxt[i]  = '0;
          w_phase_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iwClk) begin
    if (iwRst) begin
      r_meta    <= '0;
      r_sync    <= '0;
      r_div     <= '0;
      r_phase   <= '0;
      orKeyOut  <= '0;
      orPress   <= '0;
      orRelease <= '0;
      orRepeat  <= '0;
      for (int i = 0; i < int'(pChannels); i++) begin
        r_cnt[i]  <= '0;
        r_hold[i] <= '0;
      end
    end else begin
      r_meta    <= iwKeyIn;
      r_sync    <= r_meta;
      r_div     <= w_tick ? '0 : r_div + DIV_W'(1);
      r_phase   <= w_phase_nxt;
      orKeyOut  <= w_key_nxt;
      orPress   <= w_press_nxt;
      orRelease <= w_rel_nxt;
      orRepeat  <= w_rep_nxt;
      for (int i = 0; i < int'(pChannels); i++) begin
        r_cnt[i]  <= w_cnt_nxt[i];
        r_hold[i] <= w_hold_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench: instance A (tick every clock, repeat 10/4) and instance B
// (prescaler 4, no repeat), expected values hand-derived per edge.
module tb_multi_key_debouncer;

  logic       clk;
  logic       rst;
  logic [3:0] key_a, ko_a, pr_a, rl_a, rp_a;
  logic [3:0] key_b, ko_b, pr_b, rl_b, rp_b;

  int n_checks;
  int n_errors;

  multi_key_debouncer #(
    .pChannels(4), .pSampleTime(3), .pClockDividerFactor(1),
    .pRepeatDelay(10), .pRepeatPeriod(4)
  ) dut_a (
    .iwClk(clk), .iwRst(rst), .iwKeyIn(key_a),
    .orKeyOut(ko_a), .orPress(pr_a), .orRelease(rl_a), .orRepeat(rp_a)
  );

  multi_key_debouncer #(
    .pChannels(4), .pSampleTime(3), .pClockDividerFactor(4),
    .pRepeatDelay(0), .pRepeatPeriod(0)
  ) dut_b (
    .iwClk(clk), .iwRst(rst), .iwKeyIn(key_b),
    .orKeyOut(ko_b), .orPress(pr_b), .orRelease(rl_b), .orRepeat(rp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and sample just after it.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [15:0] exp_a;
  logic [3:0]  exp_b;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    key_a = '0;
    key_b = '0;
    step(3);
    check_eq("rst_a", 32'({rp_a, rl_a, pr_a, ko_a}), 32'h0);
    check_eq("rst_b", 32'({rp_b, rl_b, pr_b, ko_b}), 32'h0);
    rst = 1'b0;

    // Prescaler 4: ticks at edges 4,8,12,...; step accepted at edge 12,
    // then a 10-clock low glitch seen by the counter on edges 21..30 (ticks 24,28).
    key_b[0] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step(1);
      exp_b = {1'b0, 1'b0, (n == 12), (n >= 12)};
      check_eq("div4_ch0", 32'({rp_b[0], rl_b[0], pr_b[0], ko_b[0]}), 32'(exp_b));
      if (n == 18) key_b[0] = 1'b0;
      if (n == 28) key_b[0] = 1'b1;
    end

    // Clean step on ch0: press at 5th edge, released after edge 6 -> release at edge 11.
    key_a[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      exp_a = {4'h0, 3'b000, (k == 11), 3'b000, (k == 5), 3'b000, (k >= 5 && k < 11)};
      check_eq("step_ch0", 32'({rp_a, rl_a, pr_a, ko_a}), 32'(exp_a));
      if (k == 6) key_a[0] = 1'b0;
    end

    // Bounce on ch1: 1,1,0,1,1,0 never survives three ticks.
    for (int k = 1; k <= 12; k++) begin
      key_a[1] = (k == 1 || k == 2 || k == 4 || k == 5);
      step(1);
      check_eq("bounce_ch1", 32'({pr_a[1], ko_a[1]}), 32'h0);
    end

    // Hold ch2 for 40 clocks: press 5, repeats 15,19,..,43, release 45.
    key_a[2] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step(1);
      exp_a[3:0] = {(k >= 15 && k < 45 && ((k - 15) % 4 == 0)), (k == 45), (k == 5),
                    (k >= 5 && k < 45)};
      check_eq("hold_ch2", 32'({rp_a[2], rl_a[2], pr_a[2], ko_a[2]}), 32'(exp_a[3:0]));
      if (k == 40) key_a[2] = 1'b0;
    end

    // All channels pressed and released in the same clock.
    key_a = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      exp_a = {4'h0, 4'h0, (k == 5) ? 4'hF : 4'h0, (k >= 5) ? 4'hF : 4'h0};
      check_eq("all_press", 32'({rp_a, rl_a, pr_a, ko_a}), 32'(exp_a));
    end
    key_a = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      exp_a = {4'h0, (k == 5) ? 4'hF : 4'h0, 4'h0, (k < 5) ? 4'hF : 4'h0};
      check_eq("all_release", 32'({rp_a, rl_a, pr_a, ko_a}), 32'(exp_a));
    end

    // Reset with ch3 counter at 2, key still high: fresh press 5 edges later.
    key_a[3] = 1'b1;
    step(4);
    check_eq("pre_rst_ch3", 32'(ko_a[3]), 32'h0);
    rst = 1'b1;
    step(1);
    check_eq("mid_rst_a", 32'({rp_a, rl_a, pr_a, ko_a}), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      exp_a = {4'h0, 4'h0, (k == 5) ? 4'h8 : 4'h0, (k >= 5) ? 4'h8 : 4'h0};
      check_eq("post_rst_ch3", 32'({rp_a, rl_a, pr_a, ko_a}), 32'(exp_a));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
